// File: rtl/alu32_op_sequencer_if.sv
// Command/response/ALU bundle between the op sequencer and its environment.
// Combinational wiring only, no latency.
// Backpressure is carried by cmd_valid/cmd_ready and rsp_valid/rsp_ready.
interface alu32_op_sequencer_if;
  // Command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_wide;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;
  logic        cmd_ci;
  // ALU drive and sample
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_ci;
  logic [2:0]  alu_a;
  logic [31:0] alu_out;
  logic        alu_co;
  // Response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_co;
  logic        busy;

  // Environment side: issues commands, models the ALU, consumes responses
  modport master (
    output cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b, cmd_ci,
    output alu_out, alu_co, rsp_ready,
    input  cmd_ready, alu_in1, alu_in2, alu_ci, alu_a,
    input  rsp_valid, rsp_data, rsp_co, busy
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b, cmd_ci,
    input  alu_out, alu_co, rsp_ready,
    output cmd_ready, alu_in1, alu_in2, alu_ci, alu_a,
    output rsp_valid, rsp_data, rsp_co, busy
  );
endinterface

// File: rtl/alu32_op_sequencer.sv
// Drives a 32-bit ALU from registers, optionally as two chained passes for 64-bit ops.
// Latency: SETTLE_CYCLES edges from accept to rsp_valid (2*SETTLE_CYCLES for wide).
// Backpressure: one command in flight; cmd_ready low until the response handshakes.
module alu32_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  alu32_op_sequencer_if.slave bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_ZERO  = 3'd7;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        wide_q, wide_d;
  logic [31:0] a_hi_q, a_hi_d;
  logic [31:0] b_hi_q, b_hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] alu_in1_q, alu_in1_d;
  logic [31:0] alu_in2_q, alu_in2_d;
  logic        alu_ci_q, alu_ci_d;
  logic [2:0]  alu_a_q, alu_a_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_co_q, rsp_co_d;

  logic        settle_done;
  assign settle_done = (cnt_q == CNT_LAST);

  // Next-state and datapath: latch command, step through the passes, hold the response
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    wide_d      = wide_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    lo_d        = lo_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_ci_d    = alu_ci_q;
    alu_a_d     = alu_a_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_co_d    = rsp_co_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          // Shifts and the zero op only ever use the low pass
          wide_d    = bus.cmd_wide && (bus.cmd_op <= OP_ADD);
          a_hi_d    = bus.cmd_a[63:32];
          b_hi_d    = bus.cmd_b[63:32];
          alu_in1_d = bus.cmd_a[31:0];
          alu_in2_d = bus.cmd_b[31:0];
          alu_a_d   = bus.cmd_op;
          alu_ci_d  = (bus.cmd_op == OP_ADD) && bus.cmd_ci;
          cnt_d     = '0;
          state_d   = LO;
        end
      end

      LO: begin
        cnt_d = cnt_q + 4'd1;
        if (settle_done) begin
          lo_d = bus.alu_out;
          if (wide_q) begin
            // Second pass: upper halves, carry rippled from the low pass for ADD
            alu_in1_d = a_hi_q;
            alu_in2_d = b_hi_q;
            alu_ci_d  = (op_q == OP_ADD) && bus.alu_co;
            cnt_d     = '0;
            state_d   = HI;
          end else begin
            rsp_data_d  = {32'b0, bus.alu_out};
            rsp_co_d    = (op_q == OP_ADD) && bus.alu_co;
            rsp_valid_d = 1'b1;
            alu_a_d     = OP_ZERO;
            alu_in1_d   = '0;
            alu_in2_d   = '0;
            alu_ci_d    = 1'b0;
            state_d     = RESP;
          end
        end
      end

      HI: begin
        cnt_d = cnt_q + 4'd1;
        if (settle_done) begin
          rsp_data_d  = {bus.alu_out, lo_q};
          rsp_co_d    = (op_q == OP_ADD) && bus.alu_co;
          rsp_valid_d = 1'b1;
          alu_a_d     = OP_ZERO;
          alu_in1_d   = '0;
          alu_in2_d   = '0;
          alu_ci_d    = 1'b0;
          state_d     = RESP;
        end
      end

      RESP: begin
        // Response data is held until consumed; no new command overlaps this cycle
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight or unread work
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      wide_q      <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      lo_q        <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_ci_q    <= 1'b0;
      alu_a_q     <= OP_ZERO;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_co_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      wide_q      <= wide_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      lo_q        <= lo_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_ci_q    <= alu_ci_d;
      alu_a_q     <= alu_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_co_q    <= rsp_co_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.alu_ci    = alu_ci_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_co    = rsp_co_q;

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// Bench for alu32_op_sequencer: two instances (settle 1 and 3) behind a shared stimulus mux.
// The bench models the ALU combinationally and predicts results with 64-bit arithmetic.
// Responses are back-pressured for a random number of cycles with junk commands offered.
module tb_alu32_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic        cmd_wide;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;
  logic        cmd_ci;
  logic        rsp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  alu32_op_sequencer_if bus1 ();
  alu32_op_sequencer_if bus3 ();

  alu32_op_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  alu32_op_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  assign bus1.cmd_valid = cmd_valid && (sel == 0);
  assign bus3.cmd_valid = cmd_valid && (sel == 1);
  assign bus1.cmd_op = cmd_op;   assign bus3.cmd_op = cmd_op;
  assign bus1.cmd_wide = cmd_wide; assign bus3.cmd_wide = cmd_wide;
  assign bus1.cmd_a = cmd_a;     assign bus3.cmd_a = cmd_a;
  assign bus1.cmd_b = cmd_b;     assign bus3.cmd_b = cmd_b;
  assign bus1.cmd_ci = cmd_ci;   assign bus3.cmd_ci = cmd_ci;
  assign bus1.rsp_ready = rsp_ready; assign bus3.rsp_ready = rsp_ready;

  // ALU model; carry-out on non-ADD ops is deliberately junk (parity of In2)
  function automatic logic [32:0] alu_f(input logic [31:0] in1, input logic [31:0] in2,
                                        input logic [2:0] a, input logic ci);
    logic [32:0] s;
    case (a)
      3'd0: alu_f = {^in2, in1 & in2};
      3'd1: alu_f = {^in2, in1 | in2};
      3'd2: alu_f = {^in2, in1 ^ in2};
      3'd3: alu_f = {^in2, ~in1};
      3'd4: begin s = {1'b0, in1} + {1'b0, in2} + {32'b0, ci}; alu_f = s; end
      3'd5: alu_f = {^in2, in1 >> 1};
      3'd6: alu_f = {^in2, in1 << 1};
      default: alu_f = {^in2, 32'b0};
    endcase
  endfunction

  assign {bus1.alu_co, bus1.alu_out} = alu_f(bus1.alu_in1, bus1.alu_in2, bus1.alu_a, bus1.alu_ci);
  assign {bus3.alu_co, bus3.alu_out} = alu_f(bus3.alu_in1, bus3.alu_in2, bus3.alu_a, bus3.alu_ci);

  // Observation of the selected instance
  logic        o_cmd_ready, o_alu_ci, o_rsp_valid, o_rsp_co, o_busy;
  logic [31:0] o_alu_in1, o_alu_in2;
  logic [2:0]  o_alu_a;
  logic [63:0] o_rsp_data;
  int          settle;
  assign o_cmd_ready = (sel == 1) ? bus3.cmd_ready : bus1.cmd_ready;
  assign o_alu_ci    = (sel == 1) ? bus3.alu_ci    : bus1.alu_ci;
  assign o_rsp_valid = (sel == 1) ? bus3.rsp_valid : bus1.rsp_valid;
  assign o_rsp_co    = (sel == 1) ? bus3.rsp_co    : bus1.rsp_co;
  assign o_busy      = (sel == 1) ? bus3.busy      : bus1.busy;
  assign o_alu_in1   = (sel == 1) ? bus3.alu_in1   : bus1.alu_in1;
  assign o_alu_in2   = (sel == 1) ? bus3.alu_in2   : bus1.alu_in2;
  assign o_alu_a     = (sel == 1) ? bus3.alu_a     : bus1.alu_a;
  assign o_rsp_data  = (sel == 1) ? bus3.rsp_data  : bus1.rsp_data;
  assign settle      = (sel == 1) ? 3 : 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // Reference: whole-operation result {co, data} from plain 64/32-bit arithmetic
  function automatic logic [64:0] ref_model(input logic [2:0] op, input logic wide,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic ci);
    logic [64:0] s;
    logic [63:0] r;
    logic        co;
    logic        ew;
    ew = wide && (op <= 3'd4);
    co = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: begin
        if (ew) begin
          s = {1'b0, a} + {1'b0, b} + {64'b0, ci};
          co = s[64];
        end else begin
          s = {33'b0, a[31:0]} + {33'b0, b[31:0]} + {64'b0, ci};
          co = s[32];
        end
        r = s[63:0];
      end
      3'd5: r = {32'b0, a[31:0] >> 1};
      3'd6: r = {32'b0, a[31:0] << 1};
      default: r = 64'b0;
    endcase
    if (!ew) r[63:32] = 32'b0;
    return {co, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic wide, input logic [63:0] a,
                         input logic [63:0] b, input logic ci, input int hold);
    logic [64:0] exp;
    logic [32:0] lo_sum;
    logic        ew;
    logic        exp_ci;
    int          lat;
    int          n;
    exp    = ref_model(op, wide, a, b, ci);
    ew     = wide && (op <= 3'd4);
    lat    = ew ? 2 * settle : settle;
    lo_sum = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'b0, ci};
    cmd_op = op; cmd_wide = wide; cmd_a = a; cmd_b = b; cmd_ci = ci; cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom};
    cmd_ci = 1'($urandom); cmd_wide = 1'($urandom);
    n = 0;
    while (!o_rsp_valid && n < 64) begin
      chk("alu_opc", 64'(o_alu_a), 64'(op));
      if (n < settle) begin
        exp_ci = (op == 3'd4) ? ci : 1'b0;
        chk("lo_in1", 64'(o_alu_in1), 64'(a[31:0]));
        chk("lo_in2", 64'(o_alu_in2), 64'(b[31:0]));
      end else begin
        exp_ci = (op == 3'd4) ? lo_sum[32] : 1'b0;
        chk("hi_in1", 64'(o_alu_in1), 64'(a[63:32]));
        chk("hi_in2", 64'(o_alu_in2), 64'(b[63:32]));
      end
      chk("alu_ci", 64'(o_alu_ci), 64'(exp_ci));
      step();
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("rsp_data", o_rsp_data, exp[63:0]);
    chk("rsp_co", 64'(o_rsp_co), 64'(exp[64]));
    chk("park_opc", 64'(o_alu_a), 64'd7);
    chk("park_ops", {o_alu_in1, o_alu_in2} | 64'(o_alu_ci), 64'd0);
    chk("busy_resp", 64'(o_busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_a = {$urandom, $urandom};
      cmd_b = {$urandom, $urandom};
      chk("cmd_ready_resp", 64'(o_cmd_ready), 64'd0);
      step();
      chk("hold_valid", 64'(o_rsp_valid), 64'd1);
      chk("hold_data", o_rsp_data, exp[63:0]);
      chk("hold_co", 64'(o_rsp_co), 64'(exp[64]));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_clr", 64'(o_rsp_valid), 64'd0);
    chk("cmd_ready_back", 64'(o_cmd_ready), 64'd1);
    chk("busy_idle", 64'(o_busy), 64'd0);
    step();
    chk("no_ghost_cmd", 64'(o_busy), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(o_rsp_valid), 64'd0);
    chk({tag, "_data"}, o_rsp_data, 64'd0);
    chk({tag, "_co"}, 64'(o_rsp_co), 64'd0);
    chk({tag, "_opc"}, 64'(o_alu_a), 64'd7);
    chk({tag, "_ops"}, {o_alu_in1, o_alu_in2} | 64'(o_alu_ci), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_rdy"}, 64'(o_cmd_ready), 64'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'd0; cmd_wide = 1'b0; cmd_a = '0; cmd_b = '0; cmd_ci = 1'b0;
    repeat (3) step();
    chk_reset_state("rst1");
    sel = 1; #1;
    chk_reset_state("rst3");
    rst = 1'b0; sel = 0; #1;

    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      run_cmd(3'd4, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 0);
      run_cmd(3'd4, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0, 1);
      run_cmd(3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0);
      run_cmd(3'd2, 1'b1, 64'hAAAA_AAAA_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2);
      run_cmd(3'd6, 1'b1, 64'h1234_5678_8000_0001, 64'h5, 1'b1, 0);
      run_cmd(3'd1, 1'b0, 64'h0F0F_0000_00F0_00F0, 64'h0000_1111_0F00_0F00, 1'b0, 5);
      run_cmd(3'd1, 1'b1, 64'h0F0F_0000_00F0_00F0, 64'h0000_1111_0F00_0F00, 1'b0, 0);
      run_cmd(3'd7, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h1, 1'b1, 0);
    end

    // Reset during the high pass of a wide ADD
    sel = 0; #1;
    cmd_op = 3'd4; cmd_wide = 1'b1; cmd_a = 64'hFFFF_FFFF_FFFF_FFFF; cmd_b = 64'h1;
    cmd_ci = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("in_hi_pass", 64'(o_alu_in1), 64'hFFFF_FFFF);
    rst = 1'b1;
    step();
    chk_reset_state("rst_hi");
    rst = 1'b0; #1;
    run_cmd(3'd4, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0, 0);

    // Reset with an unread response pending
    sel = 1; #1;
    cmd_op = 3'd3; cmd_wide = 1'b0; cmd_a = 64'h1; cmd_b = 64'h0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("pending_valid", 64'(o_rsp_valid), 64'd1);
    rst = 1'b1;
    step();
    chk_reset_state("rst_rsp");
    rst = 1'b0; #1;

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 1)); #1;
      run_cmd(3'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
